// File: rtl/imgproc_pkg.sv
// Shared definitions for the image-processing pipeline: pixel word field
// positions, default frame geometry and the horizontal-blur state encoding.
package imgproc_pkg;

  localparam int X_LSB   = 41;
  localparam int X_MSB   = 49;
  localparam int Y_LSB   = 32;
  localparam int Y_MSB   = 40;
  localparam int R_LSB   = 16;
  localparam int G_LSB   = 8;
  localparam int B_LSB   = 0;
  localparam int CH_W    = 8;
  localparam int COORD_W = 9;

  localparam int DEF_LINE_W = 320;
  localparam int DEF_LINES  = 320;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ONE   = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } hblur_state_e;

endpackage

// File: rtl/hblur_kernel.sv
// Combinational 1-2-1 horizontal tap on one RGB triple; each channel sums
// into 10 bits so the worst case 4*255 cannot overflow before the shift.
module hblur_kernel
  import imgproc_pkg::*;
(
  input  logic [23:0] left_rgb,
  input  logic [23:0] centre_rgb,
  input  logic [23:0] right_rgb,
  output logic [23:0] out_rgb
);

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic [9:0] sum;
    assign sum = {2'b00, left_rgb[ch*CH_W +: CH_W]}
               + {1'b0, centre_rgb[ch*CH_W +: CH_W], 1'b0}
               + {2'b00, right_rgb[ch*CH_W +: CH_W]};
    assign out_rgb[ch*CH_W +: CH_W] = 8'(sum >> 2);
  end

endmodule

// File: rtl/hblur_stage.sv
// Streaming 3-tap horizontal blur with edge replication. Holds a left and a
// centre pixel, emits one registered output per accepted pixel plus a flush.
//
// Handshake: in_valid is a single-cycle qualifier with no back-pressure; every
// strobe is consumed on the clock edge where it is high. out_valid is likewise
// a single-cycle qualifier for out_data, with frame_done only ever high
// together with out_valid.
module hblur_stage
  import imgproc_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int LINES  = DEF_LINES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic [63:0] out_data,
  output logic        out_valid,
  output logic        frame_done,
  output logic        error,
  output logic [1:0]  dbg_state
);

  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(LINE_W - 1);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(LINES - 1);

  hblur_state_e state_q, state_d;
  logic [23:0]        l_rgb_q, l_rgb_d;
  logic [23:0]        c_rgb_q, c_rgb_d;
  logic [COORD_W-1:0] c_x_q, c_x_d;
  logic [COORD_W-1:0] c_y_q, c_y_d;
  logic               err_q, err_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [63:0]        out_data_q, out_data_d;

  logic [COORD_W-1:0] in_x, in_y, x_next;
  logic [23:0]        in_rgb;
  logic [23:0]        k_left, k_centre, k_right, k_out;
  logic               emit;
  logic               unused_in;

  assign in_x      = in_data[X_MSB:X_LSB];
  assign in_y      = in_data[Y_MSB:Y_LSB];
  assign in_rgb    = {in_data[R_LSB +: CH_W], in_data[G_LSB +: CH_W], in_data[B_LSB +: CH_W]};
  assign unused_in = ^{in_data[63:50], in_data[31:24]};
  assign x_next    = c_x_q + COORD_W'(1);

  // Single kernel shared by all emitting states; edges replicate the centre.
  always_comb begin
    k_left   = l_rgb_q;
    k_centre = c_rgb_q;
    k_right  = in_rgb;
    case (state_q)
      ST_ONE:   k_left  = c_rgb_q;
      ST_FLUSH: k_right = c_rgb_q;
      default:  ;
    endcase
  end

  hblur_kernel u_kernel (
    .left_rgb   (k_left),
    .centre_rgb (k_centre),
    .right_rgb  (k_right),
    .out_rgb    (k_out)
  );

  always_comb begin
    state_d      = state_q;
    l_rgb_d      = l_rgb_q;
    c_rgb_d      = c_rgb_q;
    c_x_d        = c_x_q;
    c_y_d        = c_y_q;
    err_d        = err_q;
    emit         = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_x == '0) begin
            c_rgb_d = in_rgb;
            c_x_d   = in_x;
            c_y_d   = in_y;
            state_d = ST_ONE;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_ONE, ST_RUN: begin
        if (in_valid) begin
          if ((state_q == ST_ONE && in_x == COORD_W'(1)) ||
              (state_q == ST_RUN && in_x == x_next)) begin
            emit    = 1'b1;
            l_rgb_d = c_rgb_q;
            c_rgb_d = in_rgb;
            c_x_d   = in_x;
            c_y_d   = in_y;
            state_d = (in_x == LAST_X) ? ST_FLUSH : ST_RUN;
          end else if (in_x == '0) begin
            // Row restarted early: abandon what we hold and begin again.
            err_d   = 1'b1;
            c_rgb_d = in_rgb;
            c_x_d   = in_x;
            c_y_d   = in_y;
            state_d = ST_ONE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_FLUSH: begin
        emit         = 1'b1;
        frame_done_d = (c_y_q == LAST_Y);
        state_d      = ST_IDLE;
        if (in_valid) begin
          if (in_x == '0) begin
            c_rgb_d = in_rgb;
            c_x_d   = in_x;
            c_y_d   = in_y;
            state_d = ST_ONE;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    out_valid_d = emit;
    out_data_d  = emit ? {14'd0, c_x_q, c_y_q, 8'd0, k_out} : out_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      l_rgb_q      <= '0;
      c_rgb_q      <= '0;
      c_x_q        <= '0;
      c_y_q        <= '0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      l_rgb_q      <= l_rgb_d;
      c_rgb_q      <= c_rgb_d;
      c_x_q        <= c_x_d;
      c_y_q        <= c_y_d;
      err_q        <= err_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;
  assign error      = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_hblur_stage.sv
// Directed bench for hblur_stage: a 4-pixel single-row instance and a
// default 320x320 instance share one input bus; a monitor logs outputs.
module tb_hblur_stage;
  import imgproc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;

  logic [63:0] a_out_data, b_out_data;
  logic        a_out_valid, b_out_valid;
  logic        a_frame_done, b_frame_done;
  logic        a_error, b_error;
  logic [1:0]  a_dbg_state, b_dbg_state;

  hblur_stage #(.LINE_W(4), .LINES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(a_out_data), .out_valid(a_out_valid), .frame_done(a_frame_done),
    .error(a_error), .dbg_state(a_dbg_state)
  );

  hblur_stage dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(b_out_data), .out_valid(b_out_valid), .frame_done(b_frame_done),
    .error(b_error), .dbg_state(b_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- monitor: {frame_done, out_data} per output ----------------
  logic        sel_b = 1'b0;
  logic [64:0] got_q[$];
  int          cyc_q[$];

  always @(negedge clk) begin
    if (sel_b ? b_out_valid : a_out_valid) begin
      got_q.push_back(sel_b ? {b_frame_done, b_out_data} : {a_frame_done, a_out_data});
      cyc_q.push_back(cyc);
    end
  end

  function automatic logic [63:0] pix(input int x, input int y, input logic [23:0] rgb);
    return {14'd0, 9'(x), 9'(y), 8'd0, rgb};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input int x, input int y, input logic [23:0] rgb);
    logic [63:0] junk;
    @(negedge clk);
    junk = {32'($urandom), 32'($urandom)};
    in_valid = 1'b1;
    in_data  = pix(x, y, rgb) | {junk[63:50], 18'd0, 32'd0} | {32'd0, junk[31:24], 24'd0};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    cyc_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = pix(0, 0, 24'h123456);
    rst_n    = 1'b0;
    #1;
    n_vec++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
    n_vec++; if (a_out_data !== 64'd0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", a_out_data); end
    n_vec++; if (a_frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b want 0", a_frame_done); end
    n_vec++; if (a_error !== 1'b0) begin n_bad++; $display("FAIL reset_error got %b want 0", a_error); end
    n_vec++; if (a_dbg_state !== 2'(ST_IDLE)) begin n_bad++; $display("FAIL reset_state got %0d want %0d", a_dbg_state, ST_IDLE); end
    idle(2);
    rst_n = 1'b1;
    got_q.delete();
    cyc_q.delete();
    sel_b = 1'b0;
    drive(2, 0, 24'h777777);
    idle(3);
    n_vec++; if (got_q.size() != 0) begin n_bad++; $display("FAIL first_nonzero_x_outputs got %0d want 0", got_q.size()); end
    n_vec++; if (a_error !== 1'b1) begin n_bad++; $display("FAIL first_nonzero_x_error got %b want 1", a_error); end
    n_vec++; if (a_dbg_state !== 2'(ST_IDLE)) begin n_bad++; $display("FAIL first_nonzero_x_state got %0d want %0d", a_dbg_state, ST_IDLE); end
  endtask

  task automatic test_row();
    logic [7:0] r_in [4]  = '{8'd0, 8'd40, 8'd80, 8'd120};
    logic [7:0] r_exp [4] = '{8'd10, 8'd40, 8'd80, 8'd110};
    logic [64:0] exp;
    do_reset();
    sel_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(i, 0, {r_in[i], 16'h0000});
      idle(3);
    end
    idle(4);
    n_vec++; if (got_q.size() != 4) begin n_bad++; $display("FAIL row_count got %0d want 4", got_q.size()); end
    if (got_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        exp = {(i == 3), pix(i, 0, {r_exp[i], 16'h0000})};
        n_vec++; if (got_q[i] !== exp) begin n_bad++; $display("FAIL row_px%0d got %h want %h", i, got_q[i], exp); end
      end
    end
    n_vec++; if (a_error !== 1'b0) begin n_bad++; $display("FAIL row_error got %b want 0", a_error); end
  endtask

  task automatic test_collision();
    logic [7:0] r_in [8]  = '{8'd0, 8'd40, 8'd80, 8'd120, 8'd200, 8'd100, 8'd0, 8'd4};
    logic [7:0] r_exp [8] = '{8'd10, 8'd40, 8'd80, 8'd110, 8'd175, 8'd100, 8'd26, 8'd3};
    logic [64:0] exp;
    do_reset();
    sel_b = 1'b0;
    for (int i = 0; i < 8; i++) drive(i % 4, 0, {8'h00, 8'h00, r_in[i]});
    idle(4);
    n_vec++; if (got_q.size() != 8) begin n_bad++; $display("FAIL collide_count got %0d want 8", got_q.size()); end
    if (got_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        exp = {(i % 4 == 3), pix(i % 4, 0, {16'h0000, r_exp[i]})};
        n_vec++; if (got_q[i] !== exp) begin n_bad++; $display("FAIL collide_px%0d got %h want %h", i, got_q[i], exp); end
      end
      n_vec++; if (cyc_q[7] - cyc_q[0] != 7) begin n_bad++; $display("FAIL collide_spacing got %0d want 7", cyc_q[7] - cyc_q[0]); end
    end
    n_vec++; if (a_error !== 1'b0) begin n_bad++; $display("FAIL collide_error got %b want 0", a_error); end
  endtask

  task automatic test_back_to_back();
    logic [64:0] exp;
    int bad_px;
    do_reset();
    sel_b = 1'b1;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 320; x++) drive(x, y, 24'hAB12CD);
    idle(4);
    n_vec++; if (got_q.size() != 640) begin n_bad++; $display("FAIL b2b_count got %0d want 640", got_q.size()); end
    if (got_q.size() == 640) begin
      bad_px = 0;
      for (int i = 0; i < 640; i++) begin
        exp = {1'b0, pix(i % 320, i / 320, 24'hAB12CD)};
        n_vec++;
        if (got_q[i] !== exp || cyc_q[i] != cyc_q[0] + i) begin
          n_bad++;
          if (bad_px < 5) $display("FAIL b2b_px%0d got %h at +%0d want %h at +%0d", i, got_q[i], cyc_q[i] - cyc_q[0], exp, i);
          bad_px++;
        end
      end
    end
    n_vec++; if (b_error !== 1'b0) begin n_bad++; $display("FAIL b2b_error got %b want 0", b_error); end
    sel_b = 1'b0;
  endtask

  task automatic test_seq_error();
    logic [64:0] exp;
    do_reset();
    sel_b = 1'b0;
    drive(0, 0, 24'h000000);
    idle(3);
    drive(1, 0, 24'h280000);
    idle(3);
    n_vec++; if (a_error !== 1'b0) begin n_bad++; $display("FAIL seq_error_early got %b want 0", a_error); end
    drive(3, 0, 24'h500000);
    idle(1);
    n_vec++; if (a_error !== 1'b1) begin n_bad++; $display("FAIL seq_error_set got %b want 1", a_error); end
    n_vec++; if (a_dbg_state !== 2'(ST_IDLE)) begin n_bad++; $display("FAIL seq_state got %0d want %0d", a_dbg_state, ST_IDLE); end
    idle(3);
    n_vec++; if (got_q.size() != 1) begin n_bad++; $display("FAIL seq_count got %0d want 1", got_q.size()); end
    exp = {1'b0, pix(0, 0, 24'h0A0000)};
    if (got_q.size() >= 1) begin
      n_vec++; if (got_q[0] !== exp) begin n_bad++; $display("FAIL seq_px0 got %h want %h", got_q[0], exp); end
    end
    drive(5, 0, 24'hFFFFFF);
    idle(3);
    n_vec++; if (got_q.size() != 1) begin n_bad++; $display("FAIL seq_drop5_count got %0d want 1", got_q.size()); end
    n_vec++; if (a_error !== 1'b1) begin n_bad++; $display("FAIL seq_sticky got %b want 1", a_error); end
    n_vec++; if (a_dbg_state !== 2'(ST_IDLE)) begin n_bad++; $display("FAIL seq_drop5_state got %0d want %0d", a_dbg_state, ST_IDLE); end
  endtask

  task automatic test_mid_row_reset();
    logic [64:0] exp;
    do_reset();
    sel_b = 1'b1;
    for (int x = 0; x <= 100; x++) drive(x, 0, 24'h102030);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    n_vec++; if (got_q.size() != 100) begin n_bad++; $display("FAIL midreset_pre_count got %0d want 100", got_q.size()); end
    repeat (2) @(negedge clk);
    got_q.delete();
    cyc_q.delete();
    rst_n = 1'b1;
    idle(5);
    n_vec++; if (got_q.size() != 0) begin n_bad++; $display("FAIL midreset_quiet got %0d want 0", got_q.size()); end
    n_vec++; if (b_error !== 1'b0) begin n_bad++; $display("FAIL midreset_error got %b want 0", b_error); end
    n_vec++; if (b_dbg_state !== 2'(ST_IDLE)) begin n_bad++; $display("FAIL midreset_state got %0d want %0d", b_dbg_state, ST_IDLE); end
    drive(0, 0, 24'h102030);
    drive(1, 0, 24'h102030);
    idle(3);
    n_vec++; if (got_q.size() != 1) begin n_bad++; $display("FAIL midreset_resume_count got %0d want 1", got_q.size()); end
    exp = {1'b0, pix(0, 0, 24'h102030)};
    if (got_q.size() >= 1) begin
      n_vec++; if (got_q[0] !== exp) begin n_bad++; $display("FAIL midreset_resume_px got %h want %h", got_q[0], exp); end
    end
    sel_b = 1'b0;
  endtask

  task automatic test_saturation();
    logic [23:0] px_in [8]  = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                                24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
    logic [23:0] px_exp [8] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                                24'hBFBFBF, 24'h7F7F7F, 24'h7F7F7F, 24'h3F3F3F};
    logic [64:0] exp;
    do_reset();
    sel_b = 1'b0;
    for (int i = 0; i < 8; i++) drive(i % 4, 0, px_in[i]);
    idle(4);
    n_vec++; if (got_q.size() != 8) begin n_bad++; $display("FAIL sat_count got %0d want 8", got_q.size()); end
    if (got_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        exp = {(i % 4 == 3), pix(i % 4, 0, px_exp[i])};
        n_vec++; if (got_q[i] !== exp) begin n_bad++; $display("FAIL sat_px%0d got %h want %h", i, got_q[i], exp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_row();
    test_collision();
    test_back_to_back();
    test_seq_error();
    test_mid_row_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
